alarm_bank: RTL and testbench
=============================

# alarm_bank

Parametrised multi-slot alarm store and matcher for the digital clock. It holds N_ALARMS independently programmable alarms, edited through the mode/inc/dec button flow. It compares every enabled slot against the running time from the timekeeping counter and raises a ring request toward the buzzer/display path. It supersedes the single-alarm setter and adds slot selection, decrement, and match/ring handling.

## Interface
- N_ALARMS, 4, number of alarm slots (2..16)
- SLOT_W, $clog2(N_ALARMS), slot index width (derived, not overridden)
- SNOOZE_MIN, 5, snooze offset in minutes (1..59; used only with ALARM_SNOOZE_EN)

- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- set_alarm_en  in  1  level; high enables editing
- mode_button  in  1  advance edit field
- inc_button  in  1  increment current field
- dec_button  in  1  decrement current field
- stop_button  in  1  dismiss ringing alarm
- snooze_button  in  1  snooze ringing alarm (ignored without ALARM_SNOOZE_EN)
- i_hours  in  5  current time hours 0..23
- i_minutes  in  6  current time minutes 0..59
- i_seconds  in  6  current time seconds 0..59
- o_slot  out  SLOT_W  slot being shown/edited
- o_hours  out  5  displayed alarm hours
- o_minutes  out  6  displayed alarm minutes
- o_enables  out  N_ALARMS  committed per-slot on/off
- ack_flag  out  1  one-cycle pulse when an edit is committed
- alarm_ring  out  1  ring request
- ring_slot  out  SLOT_W  slot that caused the current ring

## Operation
- Buttons are level inputs. Each is rising-edge detected internally, so one press equals one action regardless of hold length.
- Edit FSM states: IDLE, SEL_SLOT, SET_HOURS, SET_MINUTES, SET_ONOFF, DONE.
- IDLE→SEL_SLOT on a rising edge of set_alarm_en.
- mode edge advances the edit: SEL_SLOT→SET_HOURS (staging loaded from the selected slot), SET_HOURS→SET_MINUTES, SET_MINUTES→SET_ONOFF, SET_ONOFF→DONE.
- DONE lasts one cycle: it writes staging into the slot and pulses ack_flag, then returns to IDLE.
- inc/dec behaviour per state:
  - SEL_SLOT: slot index wraps 0..N_ALARMS-1.
  - SET_HOURS: wraps 0..23.
  - SET_MINUTES: wraps 0..59.
  - SET_ONOFF: either button toggles the on/off bit.
- Simultaneous edges:
  - mode together with inc or dec: mode wins, inc/dec discarded.
  - inc together with dec: no change.
- set_alarm_en low in any non-IDLE state: abort to IDLE next edge, staging discarded, no ack, slot unchanged.
- Display outputs:
  - Edit states: o_hours/o_minutes show staging.
  - IDLE/SEL_SLOT: they show the committed values of o_slot.
- Matching:
  - Runs in all states, against committed values only.
  - The match condition is: slot enabled, hours and minutes equal, and i_seconds == 0.
  - A ring starts on the cycle the condition goes false→true. The level condition is registered, so a stalled i_seconds never retriggers.
  - If several slots match, the lowest index wins and drives ring_slot.
  - A match while already ringing is ignored.
- alarm_ring stays high until a stop_button edge. Stop clears the ring next edge.
- Committing a slot while it rings does not clear the ring.

## Timing
- Reset values: FSM IDLE; all slots 00:00 and disabled; o_slot 0; o_hours 0; o_minutes 0; o_enables 0; ack_flag 0; alarm_ring 0; ring_slot 0; snooze state cleared.
- Button action takes effect at the first clk edge sampling the input high after a low sample. The output changes in the following cycle (1-cycle latency).
- ack_flag is high exactly one cycle, concurrent with the DONE state. o_enables reflects the new value in the same cycle.
- alarm_ring rises 1 cycle after the first cycle with i_seconds == 0 at a matching minute.
- Reset mid-ring or mid-edit clears everything immediately (asynchronous).

## Configuration
- ALARM_SNOOZE_EN defined:
  - A snooze_button edge while ringing clears alarm_ring and arms a snooze target equal to current time + SNOOZE_MIN, wrapping at 60 minutes and at 24 hours.
  - When the target is reached at seconds 0, the ring restarts with the same ring_slot.
  - A stop edge clears any pending snooze.
  - A second snooze re-arms from the time of that press.
- Not defined:
  - snooze_button is ignored; no snooze registers exist.
  - SNOOZE_MIN is unused.

## Structure
- Package alarm_pkg holds:
  - the edit FSM state enum;
  - HOURS_W = 5 and MINS_W = 6;
  - HOUR_MAX = 23 and MIN_MAX = 59;
  - wrap-increment/decrement functions for hours and minutes.
- Sub-module button_edge (2-flop edge detector with async active-low reset) is instantiated once per button input.

## Test plan
- Edit: reset; en high; inc×2 (slot 2); mode; inc×7; mode; dec×1; mode; inc; mode → slot 2 = 07:59, o_enables = 4'b0100, ack_flag for 1 cycle.
- Wrap: set hours from 0 with dec → 23; set minutes 59 with inc → 0; slot 3 with inc → 0.
- Abort: drop en in SET_MINUTES → FSM IDLE, slot unchanged, no ack.
- Match: slots 1 and 3 both 06:30 enabled; drive 06:29:59→06:30:00 with seconds held at 0 for 10 cycles → one ring, ring_slot = 1. Stop → ring low; no retrigger.
- Disabled slot: slot 0 = 00:00 off at time 00:00:00 → no ring.
- Snooze (ALARM_SNOOZE_EN): ring at 23:58, snooze, SNOOZE_MIN = 5 → ring low, restarts at 00:03:00 with the same ring_slot.

Source files
------------

// File: rtl/alarm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_pkg                                                    |
// | Description : Shared types and helpers for the alarm bank: edit FSM state  |
// |               encoding, time field widths/limits and wrap-around          |
// |               increment/decrement of hours and minutes.                   |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
package alarm_pkg;

  localparam int HOURS_W = 5;
  localparam int MINS_W  = 6;

  localparam logic [HOURS_W-1:0] HOUR_MAX = 5'd23;
  localparam logic [MINS_W-1:0]  MIN_MAX  = 6'd59;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    SEL_SLOT    = 3'd1,
    SET_HOURS   = 3'd2,
    SET_MINUTES = 3'd3,
    SET_ONOFF   = 3'd4,
    DONE        = 3'd5
  } edit_state_t;

  function automatic logic [HOURS_W-1:0] hours_inc(input logic [HOURS_W-1:0] h);
    return (h >= HOUR_MAX) ? '0 : h + 1'b1;
  endfunction

  function automatic logic [HOURS_W-1:0] hours_dec(input logic [HOURS_W-1:0] h);
    return (h == '0) ? HOUR_MAX : h - 1'b1;
  endfunction

  function automatic logic [MINS_W-1:0] mins_inc(input logic [MINS_W-1:0] m);
    return (m >= MIN_MAX) ? '0 : m + 1'b1;
  endfunction

  function automatic logic [MINS_W-1:0] mins_dec(input logic [MINS_W-1:0] m);
    return (m == '0) ? MIN_MAX : m - 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_edge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : button_edge                                                  |
// | Description : Rising-edge detector for a level button input. Two flops:   |
// |               a sample of the input and its one-cycle-old copy; the pulse |
// |               is high for exactly one cycle per low-to-high transition.   |
// | Ports       : clk, rst (async active-low), btn (level in), pulse (out)     |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module button_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic sample_q;
  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_q <= 1'b0;
      prev_q   <= 1'b0;
    end else begin
      sample_q <= btn;
      prev_q   <= sample_q;
    end
  end

  assign pulse = sample_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/alarm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alarm_bank                                                   |
// | Description : N_ALARMS-slot alarm store with a mode/inc/dec edit flow and  |
// |               a matcher that raises alarm_ring when an enabled slot hits  |
// |               the running time at seconds 0 (lowest slot index wins).     |
// | Ports       : clk, rst (async active-low); set_alarm_en, mode/inc/dec/    |
// |               stop/snooze buttons (levels); i_hours/i_minutes/i_seconds;  |
// |               o_slot, o_hours, o_minutes, o_enables, ack_flag,            |
// |               alarm_ring, ring_slot.                                      |
// | Options     : `define ALARM_SNOOZE_EN adds snooze (SNOOZE_MIN offset).    |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module alarm_bank
  import alarm_pkg::*;
#(
  parameter  int N_ALARMS   = 4,
  parameter  int SNOOZE_MIN = 5,
  localparam int SLOT_W     = $clog2(N_ALARMS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_alarm_en,
  input  logic                mode_button,
  input  logic                inc_button,
  input  logic                dec_button,
  input  logic                stop_button,
  input  logic                snooze_button,
  input  logic [HOURS_W-1:0]  i_hours,
  input  logic [MINS_W-1:0]   i_minutes,
  input  logic [MINS_W-1:0]   i_seconds,
  output logic [SLOT_W-1:0]   o_slot,
  output logic [HOURS_W-1:0]  o_hours,
  output logic [MINS_W-1:0]   o_minutes,
  output logic [N_ALARMS-1:0] o_enables,
  output logic                ack_flag,
  output logic                alarm_ring,
  output logic [SLOT_W-1:0]   ring_slot
);

  localparam int                N_BTN     = 6;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_ALARMS - 1);

  if (N_ALARMS < 2 || N_ALARMS > 16) begin : g_bad_n_alarms
    $error("alarm_bank: N_ALARMS must be 2..16");
  end
  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_bad_snooze_min
    $error("alarm_bank: SNOOZE_MIN must be 1..59");
  end

  // ---------------------------------------------------------------- buttons
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_rise;

  assign btn_level = {snooze_button, stop_button, dec_button,
                      inc_button, mode_button, set_alarm_en};

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    button_edge u_edge (
      .clk   (clk),
      .rst   (rst),
      .btn   (btn_level[g]),
      .pulse (btn_rise[g])
    );
  end

  logic en_rise, mode_rise, inc_rise, dec_rise, stop_rise, snooze_rise;
  assign {snooze_rise, stop_rise, dec_rise, inc_rise, mode_rise, en_rise} = btn_rise;

  // mode beats inc/dec; inc and dec together cancel
  logic step_up, step_dn;
  assign step_up = inc_rise & ~dec_rise & ~mode_rise;
  assign step_dn = dec_rise & ~inc_rise & ~mode_rise;

  // --------------------------------------------------------------- edit FSM
  edit_state_t state, next_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (en_rise && set_alarm_en) next_state = SEL_SLOT;
      SEL_SLOT:    if (mode_rise) next_state = SET_HOURS;
      SET_HOURS:   if (mode_rise) next_state = SET_MINUTES;
      SET_MINUTES: if (mode_rise) next_state = SET_ONOFF;
      SET_ONOFF:   if (mode_rise) next_state = DONE;
      DONE:        next_state = IDLE;
      default:     next_state = IDLE;
    endcase
    // dropping the enable abandons the edit; staging is simply never written
    if (state != IDLE && state != DONE && !set_alarm_en) next_state = IDLE;
  end

  // -------------------------------------------------------- slot store/stage
  logic [HOURS_W-1:0]  slot_hours [N_ALARMS];
  logic [MINS_W-1:0]   slot_mins  [N_ALARMS];
  logic [N_ALARMS-1:0] slot_on;
  logic [SLOT_W-1:0]   slot;
  logic [HOURS_W-1:0]  stage_hours;
  logic [MINS_W-1:0]   stage_mins;
  logic                stage_on;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot        <= '0;
      stage_hours <= '0;
      stage_mins  <= '0;
      stage_on    <= 1'b0;
      slot_on     <= '0;
      for (int i = 0; i < N_ALARMS; i++) begin
        slot_hours[i] <= '0;
        slot_mins[i]  <= '0;
      end
    end else begin
      case (state)
        SEL_SLOT: if (set_alarm_en) begin
          if (mode_rise) begin
            stage_hours <= slot_hours[slot];
            stage_mins  <= slot_mins[slot];
            stage_on    <= slot_on[slot];
          end else if (step_up) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
          end else if (step_dn) begin
            slot <= (slot == '0) ? LAST_SLOT : slot - 1'b1;
          end
        end
        SET_HOURS: begin
          if (step_up)      stage_hours <= hours_inc(stage_hours);
          else if (step_dn) stage_hours <= hours_dec(stage_hours);
        end
        SET_MINUTES: begin
          if (step_up)      stage_mins <= mins_inc(stage_mins);
          else if (step_dn) stage_mins <= mins_dec(stage_mins);
        end
        SET_ONOFF: begin
          // commit on entry to DONE so o_enables is already updated while ack is high
          if (set_alarm_en && mode_rise) begin
            slot_hours[slot] <= stage_hours;
            slot_mins[slot]  <= stage_mins;
            slot_on[slot]    <= stage_on;
          end else if (step_up || step_dn) begin
            stage_on <= ~stage_on;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_slot    = slot;
  assign o_enables = slot_on;
  assign ack_flag  = (state == DONE);

  always_comb begin
    o_hours   = stage_hours;
    o_minutes = stage_mins;
    if (state == IDLE || state == SEL_SLOT) begin
      o_hours   = slot_hours[slot];
      o_minutes = slot_mins[slot];
    end
  end

  // ---------------------------------------------------------------- matcher
  logic [N_ALARMS-1:0] match_lvl, match_prev, match_rise;
  logic [SLOT_W-1:0]   first_slot;

  always_comb begin
    match_lvl = '0;
    for (int i = 0; i < N_ALARMS; i++) begin
      match_lvl[i] = slot_on[i] && (slot_hours[i] == i_hours) &&
                     (slot_mins[i] == i_minutes) && (i_seconds == '0);
    end
  end

  // only the false-to-true transition counts, so a held seconds==0 never retriggers
  assign match_rise = match_lvl & ~match_prev;

  always_comb begin
    first_slot = '0;
    for (int i = N_ALARMS - 1; i >= 0; i--) begin
      if (match_rise[i]) first_slot = SLOT_W'(i);
    end
  end

  logic stop_evt;

`ifdef ALARM_SNOOZE_EN
  assign stop_evt = stop_rise;

  logic               snz_armed, snz_prev, snz_lvl;
  logic [HOURS_W-1:0] snz_hours, tgt_hours;
  logic [MINS_W-1:0]  snz_mins, tgt_mins;
  logic [MINS_W:0]    snz_min_sum;

  assign snz_min_sum = {1'b0, i_minutes} + 7'(SNOOZE_MIN);

  always_comb begin
    tgt_hours = i_hours;
    tgt_mins  = snz_min_sum[MINS_W-1:0];
    if (snz_min_sum > 7'(MIN_MAX)) begin
      tgt_hours = hours_inc(i_hours);
      tgt_mins  = MINS_W'(snz_min_sum - 7'd60);
    end
  end

  assign snz_lvl = snz_armed && (snz_hours == i_hours) &&
                   (snz_mins == i_minutes) && (i_seconds == '0);
`else
  // snooze has no function in this build; the term never changes stop_evt
  assign stop_evt = stop_rise | (stop_rise & snooze_rise);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alarm_ring <= 1'b0;
      ring_slot  <= '0;
      match_prev <= '0;
`ifdef ALARM_SNOOZE_EN
      snz_armed  <= 1'b0;
      snz_prev   <= 1'b0;
      snz_hours  <= '0;
      snz_mins   <= '0;
`endif
    end else begin
      match_prev <= match_lvl;
      if (alarm_ring) begin
        if (stop_evt) alarm_ring <= 1'b0;
`ifdef ALARM_SNOOZE_EN
        else if (snooze_rise) begin
          alarm_ring <= 1'b0;
          snz_armed  <= 1'b1;
          snz_hours  <= tgt_hours;
          snz_mins   <= tgt_mins;
        end
`endif
      end else if (|match_rise) begin
        alarm_ring <= 1'b1;
        ring_slot  <= first_slot;
      end
`ifdef ALARM_SNOOZE_EN
      else if (snz_lvl && !snz_prev) begin
        alarm_ring <= 1'b1;   // ring_slot still holds the snoozed slot
        snz_armed  <= 1'b0;
      end
      snz_prev <= snz_lvl;
      if (stop_evt) snz_armed <= 1'b0;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alarm_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alarm_bank                                                |
// | Description : Self-checking bench for alarm_bank. A time/slot-level model |
// |               is compared against the DUT every cycle; directed steps add |
// |               hand-computed literal expectations.                         |
// | Revision    : 1.0 - initial release                                       |
// +----------------------------------------------------------------------------+
module tb_alarm_bank;

  localparam int N   = 4;
  localparam int SW  = 2;
  localparam int SNZ = 5;

  localparam int B_EN = 0, B_MODE = 1, B_INC = 2, B_DEC = 3, B_STOP = 4, B_SNZ = 5;
  localparam int P_IDLE = 0, P_SEL = 1, P_HRS = 2, P_MIN = 3, P_ONOFF = 4, P_DONE = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, mode_b = 1'b0, inc_b = 1'b0, dec_b = 1'b0, stop_b = 1'b0, snz_b = 1'b0;
  logic [4:0] t_h = '0;
  logic [5:0] t_m = '0, t_s = '0;

  logic [SW-1:0] o_slot, ring_slot;
  logic [4:0]    o_hours;
  logic [5:0]    o_minutes;
  logic [N-1:0]  o_enables;
  logic          ack_flag, alarm_ring;

  always #5 clk = ~clk;

  alarm_bank #(.N_ALARMS(N), .SNOOZE_MIN(SNZ)) dut (
    .clk(clk), .rst(rst_n), .set_alarm_en(en),
    .mode_button(mode_b), .inc_button(inc_b), .dec_button(dec_b),
    .stop_button(stop_b), .snooze_button(snz_b),
    .i_hours(t_h), .i_minutes(t_m), .i_seconds(t_s),
    .o_slot(o_slot), .o_hours(o_hours), .o_minutes(o_minutes),
    .o_enables(o_enables), .ack_flag(ack_flag),
    .alarm_ring(alarm_ring), .ring_slot(ring_slot)
  );

  int checks = 0, errors = 0;
  int ack_count = 0, ring_rises = 0;
  logic prev_ring = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------ model
  int m_h[N], m_m[N];
  bit m_on[N], m_prev[N];
  int m_ph, m_slot, st_h, st_m;
  bit st_on, m_ring;
  int m_rslot;
  bit d1[6], d2[6];
  bit m_sarm, m_sprev;
  int sz_h, sz_m;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin m_h[i] = 0; m_m[i] = 0; m_on[i] = 0; m_prev[i] = 0; end
    for (int k = 0; k < 6; k++) begin d1[k] = 0; d2[k] = 0; end
    m_ph = P_IDLE; m_slot = 0; st_h = 0; st_m = 0; st_on = 0;
    m_ring = 0; m_rslot = 0; m_sarm = 0; m_sprev = 0; sz_h = 0; sz_m = 0;
  endtask

  task automatic model_step();
    bit cur[6], pr[6], cond[N];
    bit hit, sl, up, dn;
    int low, tot;
    cur[B_EN] = en; cur[B_MODE] = mode_b; cur[B_INC] = inc_b;
    cur[B_DEC] = dec_b; cur[B_STOP] = stop_b; cur[B_SNZ] = snz_b;
    // a press acts on the edge after the first high sample
    for (int k = 0; k < 6; k++) begin pr[k] = d1[k] && !d2[k]; d2[k] = d1[k]; d1[k] = cur[k]; end

    hit = 0; low = 0;
    for (int i = N - 1; i >= 0; i--) begin
      cond[i] = m_on[i] && m_h[i] == int'(t_h) && m_m[i] == int'(t_m) && t_s == 0;
      if (cond[i] && !m_prev[i]) begin hit = 1; low = i; end
    end
    for (int i = 0; i < N; i++) m_prev[i] = cond[i];
    sl = 0;
`ifdef ALARM_SNOOZE_EN
    sl = m_sarm && sz_h == int'(t_h) && sz_m == int'(t_m) && t_s == 0;
`endif
    if (m_ring) begin
      if (pr[B_STOP]) m_ring = 0;
`ifdef ALARM_SNOOZE_EN
      else if (pr[B_SNZ]) begin
        m_ring = 0; m_sarm = 1;
        tot = (int'(t_h) * 60 + int'(t_m) + SNZ) % 1440;
        sz_h = tot / 60; sz_m = tot % 60;
      end
`endif
    end else if (hit) begin
      m_ring = 1; m_rslot = low;
    end else if (sl && !m_sprev) begin
      m_ring = 1; m_sarm = 0;
    end
    if (pr[B_STOP]) m_sarm = 0;
    m_sprev = sl;

    up = pr[B_INC] && !pr[B_DEC] && !pr[B_MODE];
    dn = pr[B_DEC] && !pr[B_INC] && !pr[B_MODE];
    if (m_ph == P_DONE) m_ph = P_IDLE;
    else if (m_ph != P_IDLE && !en) m_ph = P_IDLE;
    else begin
      case (m_ph)
        P_IDLE: if (pr[B_EN] && en) m_ph = P_SEL;
        P_SEL: begin
          if (pr[B_MODE]) begin st_h = m_h[m_slot]; st_m = m_m[m_slot]; st_on = m_on[m_slot]; m_ph = P_HRS; end
          else if (up) m_slot = (m_slot + 1) % N;
          else if (dn) m_slot = (m_slot + N - 1) % N;
        end
        P_HRS: begin
          if (pr[B_MODE]) m_ph = P_MIN;
          else if (up) st_h = (st_h + 1) % 24;
          else if (dn) st_h = (st_h + 23) % 24;
        end
        P_MIN: begin
          if (pr[B_MODE]) m_ph = P_ONOFF;
          else if (up) st_m = (st_m + 1) % 60;
          else if (dn) st_m = (st_m + 59) % 60;
        end
        P_ONOFF: begin
          if (pr[B_MODE]) begin
            m_h[m_slot] = st_h; m_m[m_slot] = st_m; m_on[m_slot] = st_on; m_ph = P_DONE;
          end else if (up || dn) st_on = !st_on;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  always @(posedge clk) begin
    int eh, em, ee;
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    eh = (m_ph == P_IDLE || m_ph == P_SEL) ? m_h[m_slot] : st_h;
    em = (m_ph == P_IDLE || m_ph == P_SEL) ? m_m[m_slot] : st_m;
    ee = 0;
    for (int i = 0; i < N; i++) if (m_on[i]) ee += (1 << i);
    check("o_slot", 32'(o_slot), 32'(m_slot));
    check("o_hours", 32'(o_hours), 32'(eh));
    check("o_minutes", 32'(o_minutes), 32'(em));
    check("o_enables", 32'(o_enables), 32'(ee));
    check("ack_flag", 32'(ack_flag), 32'(m_ph == P_DONE));
    check("alarm_ring", 32'(alarm_ring), 32'(m_ring));
    check("ring_slot", 32'(ring_slot), 32'(m_rslot));
    if (ack_flag === 1'b1) ack_count++;
    if (alarm_ring === 1'b1 && prev_ring !== 1'b1) ring_rises++;
    prev_ring = alarm_ring;
  end

  // -------------------------------------------------------------- stimulus
  task automatic set_btn(input int which, input logic v);
    case (which)
      B_MODE: mode_b = v;
      B_INC:  inc_b  = v;
      B_DEC:  dec_b  = v;
      B_STOP: stop_b = v;
      B_SNZ:  snz_b  = v;
      default: ;
    endcase
  endtask

  task automatic press2(input int a, input int b);
    set_btn(a, 1'b1);
    if (b >= 0) set_btn(b, 1'b1);
    repeat (2) @(negedge clk);
    set_btn(a, 1'b0);
    if (b >= 0) set_btn(b, 1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int which, input int n);
    for (int k = 0; k < n; k++) press2(which, -1);
  endtask

  task automatic en_cycle();
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    t_h = 5'(h); t_m = 6'(m); t_s = 6'(s);
  endtask

  // program the currently selected slot (after slot selection) from 00:00-based deltas
  task automatic edit_fields(input int h_inc, input int m_inc, input int m_dec);
    press(B_MODE, 1);
    press(B_INC, h_inc);
    press(B_MODE, 1);
    press(B_INC, m_inc);
    press(B_DEC, m_dec);
    press(B_MODE, 1);
    press(B_INC, 1);
    press(B_MODE, 1);
  endtask

  initial begin
    set_time(0, 0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // reset values
    check("rst_o_slot", 32'(o_slot), 0);
    check("rst_o_hours", 32'(o_hours), 0);
    check("rst_o_minutes", 32'(o_minutes), 0);
    check("rst_o_enables", 32'(o_enables), 0);
    check("rst_ack", 32'(ack_flag), 0);
    check("rst_ring", 32'(alarm_ring), 0);
    check("rst_ring_slot", 32'(ring_slot), 0);

    // disabled slot 0 = 00:00 at 00:00:00 must stay silent
    repeat (5) @(negedge clk);
    check("disabled_no_ring", 32'(alarm_ring), 0);
    set_time(12, 0, 30);

    // edit: slot 2 -> 07:59 on
    en_cycle();
    press(B_INC, 2);
    check("sel_slot2", 32'(o_slot), 2);
    press(B_MODE, 1);
    press(B_INC, 7);
    press(B_MODE, 1);
    press(B_DEC, 1);
    check("stage_min_wrap_dn", 32'(o_minutes), 59);
    press(B_MODE, 1);
    press(B_INC, 1);
    press(B_MODE, 1);
    check("edit_enables", 32'(o_enables), 32'h4);
    check("edit_hours", 32'(o_hours), 7);
    check("edit_minutes", 32'(o_minutes), 59);
    check("edit_ack_once", 32'(ack_count), 1);

    // wraps, simultaneous presses, then abort in SET_MINUTES
    en_cycle();
    press(B_INC, 1);
    check("slot_to_3", 32'(o_slot), 3);
    press(B_INC, 1);
    check("slot_wrap_0", 32'(o_slot), 0);
    press2(B_INC, B_DEC);
    check("inc_dec_cancel", 32'(o_slot), 0);
    press2(B_MODE, B_INC);
    check("mode_wins_hours", 32'(o_hours), 0);
    press(B_DEC, 1);
    check("hours_wrap_23", 32'(o_hours), 23);
    press(B_MODE, 1);
    press(B_DEC, 1);
    check("min_59", 32'(o_minutes), 59);
    press(B_INC, 1);
    check("min_wrap_0", 32'(o_minutes), 0);
    en = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_hours", 32'(o_hours), 0);
    check("abort_enables", 32'(o_enables), 32'h4);
    check("abort_no_ack", 32'(ack_count), 1);

    // slots 1 and 3 = 06:30 on
    en_cycle();
    press(B_INC, 1);
    edit_fields(6, 30, 0);
    en_cycle();
    press(B_INC, 2);
    edit_fields(6, 30, 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    check("match_enables", 32'(o_enables), 32'hE);

    // match: both slots hit at 06:30:00, lowest wins, held seconds do not retrigger
    set_time(6, 29, 59);
    repeat (3) @(negedge clk);
    check("pre_match_ring", 32'(alarm_ring), 0);
    set_time(6, 30, 0);
    @(negedge clk);
    check("ring_latency", 32'(alarm_ring), 1);
    check("ring_slot_low", 32'(ring_slot), 1);
    repeat (9) @(negedge clk);
`ifndef ALARM_SNOOZE_EN
    press(B_SNZ, 1);
    check("snooze_ignored", 32'(alarm_ring), 1);
`endif
    press(B_STOP, 1);
    check("stop_clears", 32'(alarm_ring), 0);
    repeat (5) @(negedge clk);
    check("no_retrigger", 32'(alarm_ring), 0);
    check("ring_rises_once", 32'(ring_rises), 1);
    set_time(6, 30, 1);

`ifdef ALARM_SNOOZE_EN
    // slot 0 -> 23:58 on, ring, snooze to 00:03
    en_cycle();
    press(B_INC, 1);
    check("snz_sel0", 32'(o_slot), 0);
    press(B_MODE, 1);
    press(B_DEC, 1);
    press(B_MODE, 1);
    press(B_DEC, 2);
    press(B_MODE, 1);
    press(B_INC, 1);
    press(B_MODE, 1);
    en = 1'b0;
    set_time(23, 57, 59);
    repeat (2) @(negedge clk);
    set_time(23, 58, 0);
    repeat (2) @(negedge clk);
    check("snz_ring", 32'(alarm_ring), 1);
    check("snz_ring_slot", 32'(ring_slot), 0);
    press(B_SNZ, 1);
    check("snz_cleared", 32'(alarm_ring), 0);
    set_time(0, 2, 59);
    repeat (3) @(negedge clk);
    check("snz_not_yet", 32'(alarm_ring), 0);
    set_time(0, 3, 0);
    @(negedge clk);
    check("snz_restart", 32'(alarm_ring), 1);
    check("snz_same_slot", 32'(ring_slot), 0);
    press(B_STOP, 1);
    check("snz_stop", 32'(alarm_ring), 0);
`endif

    // asynchronous reset in the middle of an edit
    en_cycle();
    press(B_INC, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_slot", 32'(o_slot), 0);
    check("async_rst_enables", 32'(o_enables), 0);
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
